// File: rtl/dht11_sampler.sv
// DHT11 transaction controller: paces reads, supervises the reader handshake,
// verifies the checksum, retries failed attempts and publishes validated data.
module dht11_sampler #(
  parameter int unsigned MIN_INTERVAL = 200_000_000,
  parameter int unsigned TIMEOUT      = 10_000_000,
  parameter int unsigned ARM_CYCLES   = 4,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  output logic       BUSY,
  output logic       DONE,
  output logic       OK,
  output logic [1:0] ERR_CODE,
  output logic [7:0] HUM_I,
  output logic [7:0] HUM_F,
  output logic [7:0] TEMP_I,
  output logic [7:0] TEMP_F,
  output logic       DHT_EN,
  output logic       DHT_RST,
  input  logic       DHT_WAIT,
  input  logic       DHT_ERROR,
  input  logic [7:0] DHT_HUM_INT,
  input  logic [7:0] DHT_HUM_FLOAT,
  input  logic [7:0] DHT_TEMP_INT,
  input  logic [7:0] DHT_TEMP_FLOAT,
  input  logic [7:0] DHT_CRC
);

  localparam int unsigned IW = $clog2(MIN_INTERVAL + 1);
  localparam int unsigned TW = $clog2(((TIMEOUT > ARM_CYCLES) ? TIMEOUT : ARM_CYCLES) + 1);
  localparam int unsigned AW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, HOLDOFF, KICK, ARM, RUN, CHECK, FINISH} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_PROTO, ERR_CRC, ERR_TIMEOUT} err_t;

  state_t         st_q;
  logic [IW-1:0]  ivl_q;
  logic [TW-1:0]  to_q;
  logic [AW-1:0]  att_q;
  logic           pend_q;
  logic           sticky_q;
  logic           busy_q;
  logic           done_q;
  logic           ok_q;
  err_t           err_q;
  logic [31:0]    data_q;
  logic           en_q;
  logic           kick_q;

  logic           fail_d;
  err_t           code_d;
  logic [7:0]     sum_d;

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign OK       = ok_q;
  assign ERR_CODE = err_q;
  assign HUM_I    = data_q[31:24];
  assign HUM_F    = data_q[23:16];
  assign TEMP_I   = data_q[15:8];
  assign TEMP_F   = data_q[7:0];
  assign DHT_EN   = en_q;
  assign DHT_RST  = kick_q;

  // Attempt failure detection: arm window, run timeout, protocol and checksum faults.
  always_comb begin
    fail_d = 1'b0;
    code_d = ERR_NONE;
    sum_d  = DHT_HUM_INT + DHT_HUM_FLOAT + DHT_TEMP_INT + DHT_TEMP_FLOAT;
    case (st_q)
      ARM: if (!DHT_WAIT && to_q >= TW'(ARM_CYCLES - 1)) begin
        fail_d = 1'b1;
        code_d = ERR_TIMEOUT;
      end
      RUN: if (DHT_WAIT && to_q >= TW'(TIMEOUT - 1)) begin
        fail_d = 1'b1;
        code_d = ERR_TIMEOUT;
      end
      CHECK: if (sticky_q) begin
        fail_d = 1'b1;
        code_d = ERR_PROTO;
      end else if (sum_d != DHT_CRC) begin
        fail_d = 1'b1;
        code_d = ERR_CRC;
      end
      default: ;
    endcase
  end

  // Transaction FSM with registered handshake and result outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q     <= IDLE;
      ivl_q    <= '0;
      to_q     <= '0;
      att_q    <= '0;
      pend_q   <= 1'b0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= ERR_NONE;
      data_q   <= '0;
      en_q     <= 1'b0;
      kick_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      kick_q <= 1'b0;
      if (ivl_q < IW'(MIN_INTERVAL)) ivl_q <= ivl_q + 1'b1;
      if (REQ && st_q != IDLE) pend_q <= 1'b1;

      case (st_q)
        IDLE: if (REQ || pend_q) begin
          pend_q <= 1'b0;
          busy_q <= 1'b1;
          att_q  <= AW'(1);
          st_q   <= HOLDOFF;
        end
        HOLDOFF: if (ivl_q >= IW'(MIN_INTERVAL)) begin
          en_q   <= 1'b1;
          kick_q <= 1'b1;
          st_q   <= KICK;
        end
        KICK: begin
          ivl_q    <= '0;
          to_q     <= '0;
          sticky_q <= 1'b0;
          st_q     <= ARM;
        end
        ARM: begin
          sticky_q <= sticky_q | DHT_ERROR;
          to_q     <= to_q + 1'b1;
          if (DHT_WAIT) st_q <= RUN;
        end
        RUN: begin
          sticky_q <= sticky_q | DHT_ERROR;
          to_q     <= to_q + 1'b1;
          if (!DHT_WAIT) st_q <= CHECK;
        end
        CHECK: if (!fail_d) begin
          data_q <= {DHT_HUM_INT, DHT_HUM_FLOAT, DHT_TEMP_INT, DHT_TEMP_FLOAT};
          ok_q   <= 1'b1;
          err_q  <= ERR_NONE;
          done_q <= 1'b1;
          st_q   <= FINISH;
        end
        FINISH: begin
          busy_q <= 1'b0;
          st_q   <= IDLE;
        end
        default: st_q <= IDLE;
      endcase

      // Failures from ARM/RUN/CHECK share one retry path, overriding the state step above.
      if (fail_d) begin
        if (att_q < AW'(MAX_RETRY)) begin
          att_q <= att_q + 1'b1;
          st_q  <= HOLDOFF;
        end else begin
          ok_q   <= 1'b0;
          err_q  <= code_d;
          done_q <= 1'b1;
          st_q   <= FINISH;
        end
      end
    end
  end

endmodule
